serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor, the multi-bit stage built directly on top of the half subtractor.
- Computes `a - b` LSB-first, one bit per clock, using a full-subtractor cell (two half subtractors) plus a registered borrow.
- Operands are loaded on a start pulse. The result and final borrow are presented with a one-cycle done pulse.
- Serves as the area-cheap subtraction unit for downstream counters and comparators.

Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a subtraction; sampled only in IDLE.
- `a`, input, WIDTH: minuend, captured on the accepted start.
- `b`, input, WIDTH: subtrahend, captured on the accepted start.
- `busy`, output, 1: high while bits are being processed (SHIFT state).
- `done`, output, 1: one-cycle pulse when `diff`/`borrow` become valid.
- `diff`, output, WIDTH: `a - b` modulo 2^WIDTH.
- `borrow`, output, 1: final borrow out; 1 when unsigned `a < b`.
- `overflow`, output, 1: present only with `SERIAL_SUB_OVERFLOW_EN`; see Optional Feature.

Behaviour:
- Reset: one clock; `rst` is asynchronous and active-high.
  - `rst` high immediately forces state=IDLE, `busy`=0, `done`=0, `diff`=0, `borrow`=0, bit counter=0, internal borrow register=0, operand shift registers=0, `overflow`=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1 at edge k: latch `a` and `b` into shift registers, clear the internal borrow, counter=0, go to SHIFT.
  - `start`=0: stay in IDLE.
  - `diff`/`borrow` hold their previous values.
- SHIFT: one bit per edge, edges k+1 .. k+WIDTH.
  - With `ai`/`bi` = current LSBs and `bin` = borrow register:
    - `d = ai ^ bi ^ bin`
    - `bout = (~ai & bi) | (~(ai ^ bi) & bin)`
  - `d` shifts into the `diff` register from the MSB side. Operand registers shift right. `bin` <= `bout`. Counter increments.
  - When the counter reaches WIDTH-1 on an edge (the final bit), at that same edge k+WIDTH:
    - `borrow` <= `bout`;
    - state <= DONE;
    - `done` <= 1.
- DONE: lasts exactly one cycle. At edge k+WIDTH+1: `done` <= 0, state <= IDLE.
- Latency: `done` is high in the cycle following edge k+WIDTH, i.e. WIDTH cycles after the start edge.
  - Back-to-back throughput: one result per WIDTH+2 cycles.
- `busy`: 1 exactly in SHIFT; 0 in IDLE and DONE.
- Handshake:
  - `start` is ignored in SHIFT and DONE; no queuing.
  - `start` held high continuously is accepted again on the first IDLE edge.
- Output validity:
  - `diff` changes during SHIFT; intermediate values are not meaningful.
  - `diff`, `borrow` (and `overflow`) are guaranteed valid from the `done` cycle until the next accepted start.
- Operand inputs are don't-care except at the accepting edge.
- Wrap-around: the result is modulo 2^WIDTH, e.g. 0 - 1 gives all-ones with `borrow`=1.
- Reset mid-operation: the operation is aborted, `done` is never asserted for it, outputs go to reset values, and the FSM accepts a new start on the first edge after `rst` falls.

Optional Feature:
- Macro `SERIAL_SUB_OVERFLOW_EN`.
- Defined:
  - Adds output `overflow` (two's-complement signed overflow).
  - Registered at the final SHIFT edge as `(a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1])`, using the latched operand MSBs and the final difference MSB.
  - Reset value 0; held alongside `diff`.
- Undefined: no `overflow` port and no associated logic; all other behaviour is identical.

Test Plan (WIDTH=8):
- `a`=0x05, `b`=0x03, start pulse -> `busy` high 8 cycles; `done` one cycle, 8 cycles after the start edge; `diff`=0x02, `borrow`=0.
- `a`=0x03, `b`=0x05 -> `diff`=0xFE, `borrow`=1; `a`=0x00, `b`=0x01 -> `diff`=0xFF, `borrow`=1; `a`=0x00, `b`=0x00 -> `diff`=0x00, `borrow`=0.
- Start `a`=0x10, `b`=0x01, then 3 cycles later start again with `a`=0xAA, `b`=0x55 -> second start ignored; `diff`=0x0F, `borrow`=0; results held until the next accepted start.
- `rst` asserted asynchronously after 4 SHIFT cycles -> `busy`/`done`/`diff`/`borrow` immediately 0, no `done` pulse. After release, `a`=0x20, `b`=0x20 -> `diff`=0x00, `borrow`=0.
- With `SERIAL_SUB_OVERFLOW_EN`:
  - `a`=0x80, `b`=0x01 -> `diff`=0x7F, `borrow`=0, `overflow`=1.
  - `a`=0x7F, `b`=0xFF -> `diff`=0x80, `borrow`=1, `overflow`=1.
  - `a`=0x05, `b`=0x03 -> `overflow`=0.
- `start` held high for 30 cycles with `a`=0x09, `b`=0x04 -> a `done` pulse every 10 cycles, each with `diff`=0x05, `borrow`=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor computing a - b LSB-first.
// A full-subtractor cell built from two half subtractors processes one bit per clock.
// The borrow between bits is held in a register.
// Optional macro SERIAL_SUB_OVERFLOW_EN adds a registered two's-complement overflow output.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             borrow
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_sr, b_sr;
    logic               bin;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         fs;
    logic               last;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic               a_msb, b_msb;
`endif

    // Half subtractor: returns {difference, borrow}.
    function automatic logic [1:0] half_sub(input logic x, input logic y);
        return {x ^ y, ~x & y};
    endfunction

    // Full subtractor from two half subtractors: returns {difference, borrow out}.
    function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic bi_n);
        logic [1:0] h1, h2;
        h1 = half_sub(ai, bi);
        h2 = half_sub(h1[1], bi_n);
        return {h2[1], h1[0] | h2[0]};
    endfunction

    assign fs   = full_sub(a_sr[0], b_sr[0], bin);
    assign last = (cnt == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and state-decoded outputs; DONE lasts a single cycle.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-bit shifting, and result/borrow registration at the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            bin      <= 1'b0;
            cnt      <= '0;
            diff     <= '0;
            borrow   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            a_sr  <= a;
            b_sr  <= b;
            bin   <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            diff <= {fs[1], diff[WIDTH-1:1]};
            bin  <= fs[0];
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
                borrow   <= fs[0];
`ifdef SERIAL_SUB_OVERFLOW_EN
                // fs[1] is the bit that lands in the result MSB on this edge.
                overflow <= (a_msb != b_msb) && (fs[1] != a_msb);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): table-driven vectors plus
// hand-written sequences for ignored start, mid-operation reset and held start.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, borrow;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         overflow;
`endif

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .diff(diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .overflow(overflow),
`endif
        .borrow(borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
        logic       ov;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue a one-cycle start, wait for done, and check latency, busy length, results, pulse width.
    task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] ed, input logic eb, input logic eo);
        int lat, bcnt;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hxx; b = 8'hxx;
        lat = 0; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, W);
        check({name, " busy_cycles"}, bcnt, W);
        check({name, " diff"}, diff, ed);
        check({name, " borrow"}, borrow, eb);
        check({name, " busy_in_done"}, busy, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({name, " overflow"}, overflow, eo);
`else
        if (eo === 1'bx) $display("note: unexpected x in overflow table field");
`endif
        @(negedge clk);
        check({name, " done_one_cycle"}, done, 0);
    endtask

    initial begin
        int ndone, first_at, prev_at, gap_bad;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
        vecs[8] = '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0};

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst diff", diff, 0);
        check("rst borrow", borrow, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("rst overflow", overflow, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].ov);

        // Second start during SHIFT is ignored; result held afterwards
        begin
            int lat;
            @(negedge clk);
            a = 8'h10; b = 8'h01; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (2) @(negedge clk);
            a = 8'hAA; b = 8'h55; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            lat = 3;
            while (!done && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check("ign latency", lat, W);
            check("ign diff", diff, 8'h0F);
            check("ign borrow", borrow, 0);
            repeat (5) @(negedge clk);
            check("ign busy_after", busy, 0);
            check("ign hold diff", diff, 8'h0F);
            check("ign hold borrow", borrow, 0);
        end

        // Asynchronous reset after 4 SHIFT edges aborts the operation
        begin
            int seen;
            @(negedge clk);
            a = 8'hFF; b = 8'h00; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            check("mid busy_before", busy, 1);
            #2 rst = 1'b1;
            #1;
            check("mid busy", busy, 0);
            check("mid done", done, 0);
            check("mid diff", diff, 0);
            check("mid borrow", borrow, 0);
            @(negedge clk);
            rst = 1'b0;
            seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("mid no_done", seen, 0);
            run_op("post_rst", 8'h20, 8'h20, 8'h00, 1'b0, 1'b0);
        end

        // Start held high for 30 cycles: one result every W+2 cycles
        ndone = 0; first_at = -1; prev_at = -1; gap_bad = 0;
        @(negedge clk);
        a = 8'h09; b = 8'h04; start = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check($sformatf("held diff%0d", ndone), diff, 8'h05);
                check($sformatf("held borrow%0d", ndone), borrow, 0);
                if (first_at < 0) first_at = j;
                if (prev_at >= 0 && (j - prev_at) != W + 2) gap_bad++;
                prev_at = j;
            end
        end
        start = 1'b0;
        check("held count", ndone, 3);
        check("held first", first_at, W + 1);
        check("held spacing", gap_bad, 0);
        repeat (W + 4) @(negedge clk);
        check("held idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
